// File: rtl/fcs_pkg.sv
// Shared constants and state encoding for the Ethernet FCS stream engine.
package fcs_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    FINAL,
    DONE
  } fcs_state_t;

endpackage

// File: rtl/crc32_nbit_step.sv
// Combinational reflected CRC-32 update over N bits; bits[0] is processed first.
module crc32_nbit_step
  import fcs_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  logic [31:0]  crc_in,
  input  logic [N-1:0] bits,
  output logic [31:0]  crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < N; i++) begin
      crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ bits[i]) ? CRC32_POLY_REFL : '0);
    end
  end

endmodule

// File: rtl/fcs_stream_engine.sv
// Ethernet FCS generator: accepts stream words and serialises them lane by lane,
// BITS_PER_CYC bits per clock, into a CRC-32; MS lane of each word goes first.
module fcs_stream_engine
  import fcs_pkg::*;
#(
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned BITS_PER_CYC = 1,
  parameter int unsigned MAX_WORDS    = 64,
  parameter int unsigned BIT_ORDER    = 0
) (
  input  logic                clk_100_mhz,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [WORD_W-1:0]   s_data_i,
  input  logic [WORD_W/8-1:0] s_keep_i,
  input  logic                s_last_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic [31:0]         fcs_o,
  output logic                fcs_valid_o,
  output logic                busy_o,
  output logic [15:0]         byte_count_o,
  output logic                err_o
);

  localparam int unsigned LANES  = WORD_W / 8;
  localparam int unsigned CHUNKS = 8 / BITS_PER_CYC;
  localparam int unsigned LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned WCW    = $clog2(MAX_WORDS + 2);
  localparam int unsigned LOFF_W = $clog2(WORD_W);

  fcs_state_t              r_state;
  logic [31:0]             r_crc;
  logic [31:0]             r_fcs;
  logic                    r_fcs_valid;
  logic                    r_err;
  logic [15:0]             r_byte_cnt;
  logic [WCW-1:0]          r_word_cnt;
  logic [LW-1:0]           r_lane;
  logic [CW-1:0]           r_chunk;
  logic [WORD_W-1:0]       r_word;
  logic [LANES-1:0]        r_keep;
  logic                    r_last;

  logic [LOFF_W-1:0]       w_loff;
  logic [2:0]              w_boff;
  logic [7:0]              w_lane_byte;
  logic [7:0]              w_ord_byte;
  logic [BITS_PER_CYC-1:0] w_bits;
  logic [31:0]             w_crc_next;

  // MSB-first order is handled by mirroring the byte so chunks always slice from bit 0 up.
  always_comb begin
    w_loff      = LOFF_W'(32'(r_lane) * 8);
    w_boff      = 3'(32'(r_chunk) * BITS_PER_CYC);
    w_lane_byte = r_word[w_loff +: 8];
    w_ord_byte  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      w_ord_byte[k] = (BIT_ORDER != 0) ? w_lane_byte[7-k] : w_lane_byte[k];
    end
    w_bits = w_ord_byte[w_boff +: BITS_PER_CYC];
  end

  crc32_nbit_step #(
    .N(BITS_PER_CYC)
  ) u_step (
    .crc_in (r_crc),
    .bits   (w_bits),
    .crc_out(w_crc_next)
  );

  always_ff @(posedge clk_100_mhz) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_crc       <= CRC32_INIT;
      r_fcs       <= '0;
      r_fcs_valid <= 1'b0;
      r_err       <= 1'b0;
      r_byte_cnt  <= '0;
      r_word_cnt  <= '0;
      r_lane      <= '0;
      r_chunk     <= '0;
      r_word      <= '0;
      r_keep      <= '0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start_i) begin
            r_state     <= LOAD;
            r_crc       <= CRC32_INIT;
            r_word_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_err       <= 1'b0;
            r_fcs_valid <= 1'b0;
          end
        end
        LOAD: begin
          if (s_valid_i) begin
            r_word     <= s_data_i;
            r_keep     <= s_keep_i;
            r_last     <= s_last_i;
            r_word_cnt <= r_word_cnt + 1'b1;
            r_lane     <= LW'(LANES - 1);
            r_chunk    <= '0;
            if (r_word_cnt == WCW'(MAX_WORDS)) begin
              r_err   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          // Masked lanes still spend their cycles so word timing is fixed.
          if (r_keep[r_lane]) r_crc <= w_crc_next;
          if (r_chunk == CW'(CHUNKS - 1)) begin
            r_chunk <= '0;
            if (r_keep[r_lane] && (r_byte_cnt != '1)) r_byte_cnt <= r_byte_cnt + 16'd1;
            if (r_lane == '0) r_state <= r_last ? FINAL : LOAD;
            else              r_lane  <= r_lane - 1'b1;
          end else begin
            r_chunk <= r_chunk + 1'b1;
          end
        end
        FINAL: begin
          r_fcs       <= r_crc ^ CRC32_XOROUT;
          r_fcs_valid <= 1'b1;
          r_state     <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready_o    = (r_state == LOAD);
  assign busy_o       = (r_state == LOAD) || (r_state == SHIFT) || (r_state == FINAL);
  assign fcs_o        = r_fcs;
  assign fcs_valid_o  = r_fcs_valid;
  assign byte_count_o = r_byte_cnt;
  assign err_o        = r_err;

endmodule
